tape_ram_arbiter: RTL and testbench
===================================

Name: tape_ram_arbiter

Overview:
Shares the single Lynx main-RAM write port between the Z80 CPU and the cassette/TAP loader byte stream (tape_wr/tape_addr/tape_dout).
Loader writes arrive as one-cycle pulses at ioctl rate. They are buffered in a small in-order FIFO so no byte is dropped while the CPU owns the port.
Bank-select writes to 0xFFFF travel through the same FIFO, so their ordering against data bytes is preserved.
The CPU is stalled via cpu_wait only when tape traffic is urgent, and the stall length is bounded.

Parameters:
DEPTH, 4, FIFO entries (power of 2, at least 2); each entry is {addr[15:0], data[7:0]}.
URGENT, 3, FIFO occupancy at or above which tape pre-empts a requesting CPU.
MAX_STALL, 8, maximum consecutive tape grants while cpu_req is high before the CPU must get one grant.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
tape_wr  in  1  loader write strobe, one entry per cycle high
tape_addr  in  16  loader write address (0xFFFF = bank register)
tape_dout  in  8  loader write data
cpu_req  in  1  CPU memory write cycle pending
cpu_addr  in  16  CPU write address
cpu_dout  in  8  CPU write data
cpu_wait  out  1  stall to CPU; cpu_req must be held while this is high
ram_we  out  1  RAM write enable, registered
ram_addr  out  16  RAM address, registered
ram_din  out  8  RAM write data, registered
tape_busy  out  1  FIFO non-empty or a tape write is in flight
tape_overflow  out  1  sticky: a loader byte was dropped

Behaviour:
- Reset: FIFO empty, state IDLE, stall counter 0. Outputs: ram_we=0, ram_addr=0, ram_din=0, cpu_wait=0, tape_busy=0, tape_overflow=0. Reset asserted mid-transfer discards FIFO contents.
- FIFO push: tape_wr=1 and (count<DEPTH or a pop occurs in the same cycle).
- If tape_wr=1 while count==DEPTH with no pop, the byte is dropped and tape_overflow is set. It clears only on reset.
- Pointers wrap modulo DEPTH. Simultaneous push and pop leaves count unchanged.
- Grant decision is one per cycle, computed combinationally from the current count, cpu_req and stall_cnt:
  - cpu_req=0 and count>0 -> TAPE.
  - cpu_req=1 and count>=URGENT and stall_cnt<MAX_STALL -> TAPE.
  - cpu_req=1 otherwise -> CPU.
  - Neither condition -> IDLE.
- State register (IDLE/CPU/TAPE) holds the previous cycle's grant. It exists for the stall counter and for debug.
- TAPE grant:
  - Pop the head entry.
  - Next cycle: ram_we=1, ram_addr=head.addr, ram_din=head.data.
- CPU grant:
  - Next cycle: ram_we=1, ram_addr=cpu_addr, ram_din=cpu_dout.
- IDLE: next cycle ram_we=0. ram_addr and ram_din hold their previous values.
- Latency is exactly 1 cycle from grant to ram_we.
- Write-through: an entry pushed while the FIFO is empty can be granted no earlier than the next cycle. There is no bypass.
- cpu_wait (combinational) = cpu_req and grant==TAPE. The CPU write is performed on the first cycle it is granted.
- stall_cnt:
  - Increments on each TAPE grant while cpu_req=1, saturating at MAX_STALL.
  - Clears on any CPU grant or when cpu_req=0.
- tape_busy = (count>0) or (ram_we and the last grant was TAPE).
- FIFO order is strict: a 0xFFFF bank write is never reordered with the data bytes around it.

Decomposition:
- Shared package lynx_pkg:
  - grant-state enum IDLE/CPU/TAPE.
  - BANK_REG_ADDR = 16'hFFFF.
  - typedef tape_entry_t {addr[15:0], data[7:0]}.
- One sub-module, sync_fifo: parameterised DEPTH/WIDTH, synchronous reset, exposing push, pop, count, full and empty. The arbiter instantiates it with WIDTH=24.

Test Plan:
1. Reset, then idle CPU; pulse tape_wr with 0xFFFF/0x00, then 0x694C/0xAA -> ram_we on consecutive grants, in order 0xFFFF:0x00 then 0x694C:0xAA. cpu_wait stays 0. tape_busy falls one cycle after the last write.
2. cpu_req held high with cpu_addr 0x1234/0x55; push 2 tape entries -> CPU granted, 0x1234:0x55 written next cycle. Tape entries stay queued and drain when cpu_req drops.
3. cpu_req held high; push 3 entries (count=3=URGENT) -> cpu_wait=1 while occupancy ≥ URGENT; as soon as it drops below URGENT the CPU is granted and cpu_wait clears.
4. Starvation bound with URGENT=2, MAX_STALL=2: keep count ≥2 by pushing every cycle while cpu_req=1 -> at most 2 consecutive TAPE grants, then one CPU grant, and the pattern repeats.
5. Overflow with DEPTH=4: cpu_req held high, count<URGENT blocked by forcing URGENT=5; push 5 entries -> the fifth is dropped and tape_overflow=1. The remaining 4 drain in order. The flag clears only on reset.
6. Assert reset with 3 entries queued and ram_we=1 -> the next cycle has ram_we=0, tape_busy=0, cpu_wait=0 and the FIFO empty. No stale entries are written afterwards.

Source files
------------

// File: rtl/lynx_pkg.sv
// Shared types for the Lynx main-RAM write-port arbitration: grant state,
// tape FIFO entry layout and the bank-register address.
package lynx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CPU  = 2'd1,
    TAPE = 2'd2
  } grant_t;

  localparam logic [15:0] BANK_REG_ADDR = 16'hFFFF;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } tape_entry_t;

  localparam int ENTRY_W = $bits(tape_entry_t);

endpackage

// File: rtl/sync_fifo.sv
// Small in-order FIFO with occupancy count; head entry is visible on rdata
// without a read latency.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 24
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define
  // validity, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/tape_ram_arbiter.sv
// Arbitrates the Lynx main-RAM write port between the Z80 and the buffered
// tape loader stream, stalling the CPU only for urgent and bounded bursts.
module tape_ram_arbiter
  import lynx_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int URGENT    = 3,
  parameter int MAX_STALL = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tape_wr,
  input  logic [15:0] tape_addr,
  input  logic [7:0]  tape_dout,
  input  logic        cpu_req,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  output logic        cpu_wait,
  output logic        ram_we,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_din,
  output logic        tape_busy,
  output logic        tape_overflow
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(MAX_STALL + 1);

  grant_t         state;
  grant_t         grant;
  logic [SW-1:0]  stall_cnt;
  logic [CW-1:0]  count;
  logic           full;
  logic           empty;
  logic           pop;
  tape_entry_t    wr_entry;
  tape_entry_t    head;

  assign wr_entry = '{addr: tape_addr, data: tape_dout};

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tape_wr),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // State register: previous grant and the consecutive-stall counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      stall_cnt <= '0;
    end else begin
      state <= grant;
      if (!cpu_req || grant == CPU)
        stall_cnt <= '0;
      else if (grant == TAPE && int'(stall_cnt) < MAX_STALL)
        stall_cnt <= stall_cnt + SW'(1);
    end
  end

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    grant = IDLE;
    if (!cpu_req && !empty)
      grant = TAPE;
    else if (cpu_req && int'(count) >= URGENT && int'(stall_cnt) < MAX_STALL)
      grant = TAPE;
    else if (cpu_req)
      grant = CPU;
  end

  always_comb begin
    pop       = (grant == TAPE);
    cpu_wait  = cpu_req && (grant == TAPE);
    tape_busy = !empty || (ram_we && state == TAPE);
  end

  // RAM port is registered: exactly one cycle from grant to ram_we.
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
    end else begin
      ram_we <= (grant != IDLE);
      case (grant)
        TAPE: begin
          ram_addr <= head.addr;
          ram_din  <= head.data;
        end
        CPU: begin
          ram_addr <= cpu_addr;
          ram_din  <= cpu_dout;
        end
        default: begin
          ram_addr <= ram_addr;
          ram_din  <= ram_din;
        end
      endcase
    end
  end

  // Sticky until reset: a loader byte arrived with no room and no pop.
  always_ff @(posedge clk) begin
    if (reset)
      tape_overflow <= 1'b0;
    else if (tape_wr && full && !pop)
      tape_overflow <= 1'b1;
  end

endmodule

// File: tb/tb_tape_ram_arbiter.sv
// Directed bench for tape_ram_arbiter: three instances share stimulus, one per
// parameter set (default, tight stall bound, never-urgent overflow).
module tb_tape_ram_arbiter;

  logic        clk;
  logic        reset;
  logic        tape_wr;
  logic [15:0] tape_addr;
  logic [7:0]  tape_dout;
  logic        cpu_req;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;

  logic        a_cpu_wait, a_ram_we, a_tape_busy, a_tape_overflow;
  logic [15:0] a_ram_addr;
  logic [7:0]  a_ram_din;
  logic        b_cpu_wait, b_ram_we, b_tape_busy, b_tape_overflow;
  logic [15:0] b_ram_addr;
  logic [7:0]  b_ram_din;
  logic        c_cpu_wait, c_ram_we, c_tape_busy, c_tape_overflow;
  logic [15:0] c_ram_addr;
  logic [7:0]  c_ram_din;

  int checks = 0;
  int failures = 0;

  tape_ram_arbiter u_dut (
    .clk(clk), .reset(reset), .tape_wr(tape_wr), .tape_addr(tape_addr),
    .tape_dout(tape_dout), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_dout(cpu_dout), .cpu_wait(a_cpu_wait), .ram_we(a_ram_we),
    .ram_addr(a_ram_addr), .ram_din(a_ram_din), .tape_busy(a_tape_busy),
    .tape_overflow(a_tape_overflow)
  );

  tape_ram_arbiter #(.DEPTH(4), .URGENT(2), .MAX_STALL(2)) u_stall (
    .clk(clk), .reset(reset), .tape_wr(tape_wr), .tape_addr(tape_addr),
    .tape_dout(tape_dout), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_dout(cpu_dout), .cpu_wait(b_cpu_wait), .ram_we(b_ram_we),
    .ram_addr(b_ram_addr), .ram_din(b_ram_din), .tape_busy(b_tape_busy),
    .tape_overflow(b_tape_overflow)
  );

  tape_ram_arbiter #(.DEPTH(4), .URGENT(5), .MAX_STALL(8)) u_ovf (
    .clk(clk), .reset(reset), .tape_wr(tape_wr), .tape_addr(tape_addr),
    .tape_dout(tape_dout), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_dout(cpu_dout), .cpu_wait(c_cpu_wait), .ram_we(c_ram_we),
    .ram_addr(c_ram_addr), .ram_din(c_ram_din), .tape_busy(c_tape_busy),
    .tape_overflow(c_tape_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tape_wr = 1'b0; tape_addr = '0; tape_dout = '0;
    cpu_req = 1'b0; cpu_addr = '0; cpu_dout = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tape_wr = 1'b0; tape_addr = '0; tape_dout = '0;
    cpu_req = 1'b0; cpu_addr = '0; cpu_dout = '0;
    tick();
    tick();
    checks++;
    if ({a_ram_we, a_ram_addr, a_ram_din} !== 25'h0) begin
      failures++;
      $display("FAIL reset_ram got=%h exp=%h", {a_ram_we, a_ram_addr, a_ram_din}, 25'h0);
    end
    checks++;
    if ({a_cpu_wait, a_tape_busy, a_tape_overflow} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=000", {a_cpu_wait, a_tape_busy, a_tape_overflow});
    end
    reset = 1'b0;
  endtask

  task automatic test_fifo_order();
    do_reset();
    tape_wr = 1'b1; tape_addr = 16'hFFFF; tape_dout = 8'h00;
    tick();
    tape_addr = 16'h694C; tape_dout = 8'hAA;
    tick();
    tape_wr = 1'b0;
    checks++;
    if ({a_ram_we, a_ram_addr, a_ram_din} !== {1'b1, 16'hFFFF, 8'h00}) begin
      failures++;
      $display("FAIL order_bank got=%h exp=%h", {a_ram_we, a_ram_addr, a_ram_din}, {1'b1, 16'hFFFF, 8'h00});
    end
    checks++;
    if (a_cpu_wait !== 1'b0) begin
      failures++;
      $display("FAIL order_wait got=%b exp=0", a_cpu_wait);
    end
    tick();
    checks++;
    if ({a_ram_we, a_ram_addr, a_ram_din} !== {1'b1, 16'h694C, 8'hAA}) begin
      failures++;
      $display("FAIL order_data got=%h exp=%h", {a_ram_we, a_ram_addr, a_ram_din}, {1'b1, 16'h694C, 8'hAA});
    end
    checks++;
    if (a_tape_busy !== 1'b1) begin
      failures++;
      $display("FAIL order_busy_inflight got=%b exp=1", a_tape_busy);
    end
    tick();
    checks++;
    if ({a_ram_we, a_ram_addr, a_tape_busy} !== {1'b0, 16'h694C, 1'b0}) begin
      failures++;
      $display("FAIL order_idle got=%h exp=%h", {a_ram_we, a_ram_addr, a_tape_busy}, {1'b0, 16'h694C, 1'b0});
    end
  endtask

  task automatic test_cpu_priority();
    do_reset();
    cpu_req = 1'b1; cpu_addr = 16'h1234; cpu_dout = 8'h55;
    tape_wr = 1'b1; tape_addr = 16'h1000; tape_dout = 8'h11;
    #1;
    checks++;
    if (a_cpu_wait !== 1'b0) begin
      failures++;
      $display("FAIL cpu_wait_low got=%b exp=0", a_cpu_wait);
    end
    tick();
    tape_addr = 16'h1001; tape_dout = 8'h22;
    checks++;
    if ({a_ram_we, a_ram_addr, a_ram_din} !== {1'b1, 16'h1234, 8'h55}) begin
      failures++;
      $display("FAIL cpu_write got=%h exp=%h", {a_ram_we, a_ram_addr, a_ram_din}, {1'b1, 16'h1234, 8'h55});
    end
    tick();
    tape_wr = 1'b0;
    checks++;
    if (a_tape_busy !== 1'b1) begin
      failures++;
      $display("FAIL cpu_queue_busy got=%b exp=1", a_tape_busy);
    end
    tick();
    cpu_req = 1'b0;
    tick();
    checks++;
    if ({a_ram_we, a_ram_addr, a_ram_din} !== {1'b1, 16'h1000, 8'h11}) begin
      failures++;
      $display("FAIL cpu_drain0 got=%h exp=%h", {a_ram_we, a_ram_addr, a_ram_din}, {1'b1, 16'h1000, 8'h11});
    end
    tick();
    checks++;
    if ({a_ram_we, a_ram_addr, a_ram_din} !== {1'b1, 16'h1001, 8'h22}) begin
      failures++;
      $display("FAIL cpu_drain1 got=%h exp=%h", {a_ram_we, a_ram_addr, a_ram_din}, {1'b1, 16'h1001, 8'h22});
    end
    tick();
    checks++;
    if ({a_ram_we, a_tape_busy} !== 2'b00) begin
      failures++;
      $display("FAIL cpu_drain_done got=%b exp=00", {a_ram_we, a_tape_busy});
    end
  endtask

  task automatic test_urgent();
    do_reset();
    cpu_req = 1'b1; cpu_addr = 16'h2000; cpu_dout = 8'h77;
    for (int i = 0; i < 3; i++) begin
      tape_wr = 1'b1; tape_addr = 16'h3000 + 16'(i); tape_dout = 8'h01 + 8'(i);
      tick();
    end
    tape_wr = 1'b0;
    #1;
    checks++;
    if (a_cpu_wait !== 1'b1) begin
      failures++;
      $display("FAIL urgent_wait got=%b exp=1", a_cpu_wait);
    end
    tick();
    checks++;
    if ({a_ram_we, a_ram_addr, a_ram_din} !== {1'b1, 16'h3000, 8'h01}) begin
      failures++;
      $display("FAIL urgent_tape got=%h exp=%h", {a_ram_we, a_ram_addr, a_ram_din}, {1'b1, 16'h3000, 8'h01});
    end
    checks++;
    if (a_cpu_wait !== 1'b0) begin
      failures++;
      $display("FAIL urgent_release got=%b exp=0", a_cpu_wait);
    end
    tick();
    checks++;
    if ({a_ram_we, a_ram_addr, a_ram_din} !== {1'b1, 16'h2000, 8'h77}) begin
      failures++;
      $display("FAIL urgent_cpu got=%h exp=%h", {a_ram_we, a_ram_addr, a_ram_din}, {1'b1, 16'h2000, 8'h77});
    end
    cpu_req = 1'b0;
    tick();
    checks++;
    if ({a_ram_we, a_ram_addr, a_ram_din} !== {1'b1, 16'h3001, 8'h02}) begin
      failures++;
      $display("FAIL urgent_drain1 got=%h exp=%h", {a_ram_we, a_ram_addr, a_ram_din}, {1'b1, 16'h3001, 8'h02});
    end
    tick();
    checks++;
    if ({a_ram_we, a_ram_addr, a_ram_din} !== {1'b1, 16'h3002, 8'h03}) begin
      failures++;
      $display("FAIL urgent_drain2 got=%h exp=%h", {a_ram_we, a_ram_addr, a_ram_din}, {1'b1, 16'h3002, 8'h03});
    end
  endtask

  // URGENT=2, MAX_STALL=2 instance: grants after edges 1..11 are
  // C C T T C T T C T T C with a push on each of the first 8 edges.
  task automatic test_starvation();
    bit is_tape [1:11];
    int di;
    logic [24:0] exp_w;
    is_tape = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    di = 0;
    do_reset();
    cpu_req = 1'b1; cpu_addr = 16'h5000; cpu_dout = 8'hEE;
    tape_wr = 1'b1; tape_addr = 16'h4000; tape_dout = 8'h00;
    for (int k = 1; k <= 11; k++) begin
      #1;
      checks++;
      if (b_cpu_wait !== is_tape[k]) begin
        failures++;
        $display("FAIL stall_wait_%0d got=%b exp=%b", k, b_cpu_wait, is_tape[k]);
      end
      tick();
      if (is_tape[k]) begin
        exp_w = {1'b1, 16'h4000 + 16'(di), 8'(di)};
        di++;
      end else begin
        exp_w = {1'b1, 16'h5000, 8'hEE};
      end
      checks++;
      if ({b_ram_we, b_ram_addr, b_ram_din} !== exp_w) begin
        failures++;
        $display("FAIL stall_grant_%0d got=%h exp=%h", k, {b_ram_we, b_ram_addr, b_ram_din}, exp_w);
      end
      if (k < 8) begin
        tape_wr = 1'b1; tape_addr = 16'h4000 + 16'(k); tape_dout = 8'(k);
      end else begin
        tape_wr = 1'b0;
      end
    end
    checks++;
    if (b_tape_overflow !== 1'b0) begin
      failures++;
      $display("FAIL stall_no_overflow got=%b exp=0", b_tape_overflow);
    end
    cpu_req = 1'b0;
  endtask

  task automatic test_overflow();
    do_reset();
    cpu_req = 1'b1; cpu_addr = 16'h6000; cpu_dout = 8'h99;
    for (int i = 0; i < 5; i++) begin
      tape_wr = 1'b1; tape_addr = 16'h7000 + 16'(i); tape_dout = 8'h10 + 8'(i);
      tick();
      if (i == 3) begin
        checks++;
        if (c_tape_overflow !== 1'b0) begin
          failures++;
          $display("FAIL ovf_early got=%b exp=0", c_tape_overflow);
        end
      end
    end
    tape_wr = 1'b0;
    checks++;
    if (c_tape_overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_set got=%b exp=1", c_tape_overflow);
    end
    cpu_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({c_ram_we, c_ram_addr, c_ram_din} !== {1'b1, 16'h7000 + 16'(i), 8'h10 + 8'(i)}) begin
        failures++;
        $display("FAIL ovf_drain_%0d got=%h exp=%h", i, {c_ram_we, c_ram_addr, c_ram_din},
                 {1'b1, 16'h7000 + 16'(i), 8'h10 + 8'(i)});
      end
    end
    tick();
    checks++;
    if ({c_ram_we, c_tape_busy, c_tape_overflow} !== 3'b001) begin
      failures++;
      $display("FAIL ovf_sticky got=%b exp=001", {c_ram_we, c_tape_busy, c_tape_overflow});
    end
    do_reset();
    checks++;
    if (c_tape_overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear got=%b exp=0", c_tape_overflow);
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    cpu_req = 1'b1; cpu_addr = 16'h2222; cpu_dout = 8'h33;
    for (int i = 0; i < 4; i++) begin
      tape_wr = 1'b1; tape_addr = 16'h8000 + 16'(i); tape_dout = 8'hB0 + 8'(i);
      tick();
    end
    checks++;
    if ({a_ram_we, a_ram_addr, a_ram_din, a_tape_busy} !== {1'b1, 16'h8000, 8'hB0, 1'b1}) begin
      failures++;
      $display("FAIL rst_pre got=%h exp=%h", {a_ram_we, a_ram_addr, a_ram_din, a_tape_busy},
               {1'b1, 16'h8000, 8'hB0, 1'b1});
    end
    reset = 1'b1; cpu_req = 1'b0; tape_wr = 1'b0;
    tick();
    checks++;
    if ({a_ram_we, a_tape_busy, a_cpu_wait} !== 3'b000) begin
      failures++;
      $display("FAIL rst_mid got=%b exp=000", {a_ram_we, a_tape_busy, a_cpu_wait});
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({a_ram_we, a_tape_busy} !== 2'b00) begin
        failures++;
        $display("FAIL rst_stale_%0d got=%b exp=00", i, {a_ram_we, a_tape_busy});
      end
    end
  endtask

  initial begin
    test_reset();
    test_fifo_order();
    test_cpu_priority();
    test_urgent();
    test_starvation();
    test_overflow();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
